// File: rtl/led_trace_capture_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_trace_capture_pkg                                                |
// | Shared widths for the LED bus, the cycle timestamp and trace depth.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package led_trace_capture_pkg;
  localparam int c_LED_W  = 8;
  localparam int c_TS_W   = 16;
  localparam int c_DEPTH  = 16;
  localparam int c_ADDR_W = 4;
endpackage
`default_nettype wire

// File: rtl/led_trace_capture_trace_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_fifo                                                           |
// | First-word-fall-through FIFO holding {led, timestamp} trace entries. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module trace_fifo #(
  parameter int WIDTH  = 24,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count
);

  localparam logic [ADDR_W:0] c_FULL = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              w_empty;
  logic              w_rd;
  logic              w_wr;
  logic [ADDR_W:0]   w_count_nxt;

  assign w_empty = (r_count == '0);
  assign w_rd    = i_pop & ~w_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_wr    = i_push & (~r_full | w_rd);

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_rd)
      w_count_nxt = r_count + 1'b1;
    else if (w_rd && !w_wr)
      w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wr_ptr] <= i_wdata;
  end

  // Storage is not reset, so mask the head while nothing valid is stored.
  assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/led_trace_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_trace_capture                                                    |
// | Records LED bus value changes with cycle timestamps into a FIFO.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module led_trace_capture
  import led_trace_capture_pkg::*;
#(
  parameter int DATA_W = c_LED_W,
  parameter int TS_W   = c_TS_W,
  parameter int DEPTH  = c_DEPTH,
  parameter int ADDR_W = c_ADDR_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iEnable,
  input  logic [DATA_W-1:0] iLed,
  input  logic              iReady,
  input  logic              iClearOvf,
  output logic              oValid,
  output logic [DATA_W-1:0] oData,
  output logic [TS_W-1:0]   oTimestamp,
  output logic [ADDR_W:0]   oCount,
  output logic              oFull,
  output logic              oOverflow
);

  localparam int c_ENTRY_W = DATA_W + TS_W;

  logic [TS_W-1:0]      r_ts;
  logic [DATA_W-1:0]    r_prev;
  logic                 r_end;
  logic                 r_ovf;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [c_ENTRY_W-1:0] w_rdata;

  // The first enabled cycle always logs a baseline, later cycles only on change.
  assign w_push = iEnable & (~r_end | (iLed != r_prev));
  assign w_pop  = ~w_empty & iReady;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_ts   <= '0;
      r_prev <= '0;
      r_end  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_ts   <= iEnable ? r_ts + 1'b1 : '0;
      r_prev <= iLed;
      r_end  <= iEnable;
      if (w_push && w_full && !w_pop)
        r_ovf <= 1'b1;
      else if (iClearOvf)
        r_ovf <= 1'b0;
    end
  end

  trace_fifo #(
    .WIDTH  (c_ENTRY_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (Clock),
    .rst_n   (Reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({iLed, r_ts}),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (oCount)
  );

  assign oValid     = ~w_empty;
  assign oData      = w_rdata[c_ENTRY_W-1:TS_W];
  assign oTimestamp = w_rdata[TS_W-1:0];
  assign oFull      = w_full;
  assign oOverflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_led_trace_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_led_trace_capture                                                 |
// | Directed checks of change capture, FIFO limits, overflow and wrap.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_led_trace_capture;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        iEnable = 1'b0;
  logic [7:0]  iLed = 8'h00;
  logic        iReady = 1'b0;
  logic        iClearOvf = 1'b0;
  logic        oValid;
  logic [7:0]  oData;
  logic [15:0] oTimestamp;
  logic [4:0]  oCount;
  logic        oFull;
  logic        oOverflow;

  logic        e4_enable = 1'b0;
  logic [7:0]  e4_led = 8'h00;
  logic        e4_ready = 1'b0;
  logic        e4_valid;
  logic [7:0]  e4_data;
  logic [3:0]  e4_ts;
  logic [4:0]  e4_count;
  logic        e4_full;
  logic        e4_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 Clock = ~Clock;

  led_trace_capture u_dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .iEnable    (iEnable),
    .iLed       (iLed),
    .iReady     (iReady),
    .iClearOvf  (iClearOvf),
    .oValid     (oValid),
    .oData      (oData),
    .oTimestamp (oTimestamp),
    .oCount     (oCount),
    .oFull      (oFull),
    .oOverflow  (oOverflow)
  );

  led_trace_capture #(.TS_W(4)) u_dut_ts4 (
    .Clock      (Clock),
    .Reset      (Reset),
    .iEnable    (e4_enable),
    .iLed       (e4_led),
    .iReady     (e4_ready),
    .iClearOvf  (1'b0),
    .oValid     (e4_valid),
    .oData      (e4_data),
    .oTimestamp (e4_ts),
    .oCount     (e4_count),
    .oFull      (e4_full),
    .oOverflow  (e4_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_valid", oValid, 0);
    chk("rst_count", oCount, 0);
    chk("rst_full", oFull, 0);
    chk("rst_ovf", oOverflow, 0);
    chk("rst_data", oData, 0);
    chk("rst_ts", oTimestamp, 0);
    Reset = 1'b1;
    tick();

    // Changes at ts 0, 4 and 9 with a consumer always ready.
    iEnable = 1'b1; iLed = 8'h00; iReady = 1'b1;
    tick();
    chk("t2_v0", oValid, 1);
    chk("t2_d0", oData, 8'h00);
    chk("t2_ts0", oTimestamp, 0);
    tick();
    chk("t2_drained0", oValid, 0);
    repeat (2) tick();
    iLed = 8'h01;
    tick();
    chk("t2_v1", oValid, 1);
    chk("t2_d1", oData, 8'h01);
    chk("t2_ts1", oTimestamp, 4);
    tick();
    chk("t2_drained1", oValid, 0);
    repeat (3) tick();
    iLed = 8'h03;
    tick();
    chk("t2_v2", oValid, 1);
    chk("t2_d2", oData, 8'h03);
    chk("t2_ts2", oTimestamp, 9);
    tick();
    chk("t2_empty", oCount, 0);

    // Constant bus: only the baseline entry.
    iEnable = 1'b0; iReady = 1'b0;
    tick();
    iEnable = 1'b1; iLed = 8'h5A;
    repeat (50) tick();
    chk("t3_count", oCount, 1);
    chk("t3_data", oData, 8'h5A);
    chk("t3_ts", oTimestamp, 0);
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    chk("t3_drained", oCount, 0);

    // Toggle every cycle without a consumer: fill then overflow.
    iEnable = 1'b0;
    tick();
    iEnable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      iLed = (i % 2 == 1) ? 8'h3C : 8'hC3;
      tick();
    end
    chk("t4_count", oCount, 16);
    chk("t4_full", oFull, 1);
    chk("t4_ovf", oOverflow, 1);
    chk("t4_head_d", oData, 8'hC3);
    chk("t4_head_ts", oTimestamp, 0);
    iLed = 8'hC3; iClearOvf = 1'b1;
    tick();
    chk("t4_set_beats_clr", oOverflow, 1);
    chk("t4_count_held", oCount, 16);
    tick();
    chk("t4_cleared", oOverflow, 0);
    iClearOvf = 1'b0;

    // Full FIFO, push and pop together at ts 22.
    iLed = 8'h77; iReady = 1'b1;
    tick();
    chk("t5_count", oCount, 16);
    chk("t5_full", oFull, 1);
    chk("t5_ovf", oOverflow, 0);
    chk("t5_head_d", oData, 8'h3C);
    chk("t5_head_ts", oTimestamp, 1);
    repeat (15) tick();
    chk("t5_tail_count", oCount, 1);
    chk("t5_tail_d", oData, 8'h77);
    chk("t5_tail_ts", oTimestamp, 22);
    tick();
    chk("t5_drained", oCount, 0);
    iReady = 1'b0;

    // Asynchronous reset mid-fill.
    for (int i = 0; i < 5; i++) begin
      iLed = (i % 2 == 1) ? 8'h11 : 8'h22;
      tick();
    end
    chk("t1_prefill", oCount, 5);
    #3 Reset = 1'b0;
    #1;
    chk("t1_async_valid", oValid, 0);
    chk("t1_async_count", oCount, 0);
    chk("t1_async_ovf", oOverflow, 0);
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b1;
    iEnable = 1'b0;
    chk("t1_rel_valid", oValid, 0);
    chk("t1_rel_count", oCount, 0);
    tick();
    chk("t1_idle_count", oCount, 0);

    // 4-bit timestamp: change 17 cycles after enable lands on ts 1.
    e4_enable = 1'b1; e4_led = 8'h00;
    tick();
    repeat (16) tick();
    e4_led = 8'h01;
    tick();
    chk("t6_count", e4_count, 2);
    e4_ready = 1'b1;
    tick();
    e4_ready = 1'b0;
    chk("t6_data", e4_data, 8'h01);
    chk("t6_ts_wrap", e4_ts, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
